// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - md_op codes, default latencies and op classification for md_sched (option MD_MADD_EN)
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit and commit through the pending registers.
  function automatic logic is_long_op(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_long_op = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MSUB: is_long_op = 1'b1;
`endif
      default: is_long_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational {hi,lo} result of a mult/div op (madd/msub under MD_MADD_EN)
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;
  logic        [31:0] u_quo;
  logic        [31:0] u_rem;
  logic               div_zero;

  assign s_prod   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign u_prod   = {32'd0, rs_val} * {32'd0, rt_val};
  assign div_zero = (rt_val == 32'd0);
  // Divider inputs are forced non-zero so the quotient is never undefined; the result is discarded anyway.
  assign s_quo    = $signed(rs_val) / $signed(div_zero ? 32'd1 : rt_val);
  assign s_rem    = $signed(rs_val) % $signed(div_zero ? 32'd1 : rt_val);
  assign u_quo    = rs_val / (div_zero ? 32'd1 : rt_val);
  assign u_rem    = rs_val % (div_zero ? 32'd1 : rt_val);

  always_comb begin
    result = {hi, lo};
    case (md_op)
      MD_MULT:  result = s_prod;
      MD_MULTU: result = u_prod;
      MD_DIV:   if (!div_zero) result = {s_rem, s_quo};
      MD_DIVU:  if (!div_zero) result = {u_rem, u_quo};
`ifdef MD_MADD_EN
      MD_MADD:  result = {hi, lo} + s_prod;
      MD_MSUB:  result = {hi, lo} - s_prod;
`endif
      default:  result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide sequencer with HI/LO registers and D-stage stall (option MD_MADD_EN)
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      p_hi, p_lo;
  logic [63:0]      result;
  logic             issue, commit, wr_hi, wr_lo, long_req;

  md_arith u_arith (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  assign long_req = start && is_long_op(md_op);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    issue   = 1'b0;
    commit  = 1'b0;
    done    = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (long_req) begin
          issue   = 1'b1;
          state_n = BUSY;
          cnt_n   = is_div_op(md_op) ? DIV_LOAD : MULT_LOAD;
        end else begin
          wr_hi = start && (md_op == MD_MTHI);
          wr_lo = start && (md_op == MD_MTLO);
        end
      end
      BUSY: begin
        // Any start seen here is ignored; the stall keeps the pipeline from sending one.
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit  = 1'b1;
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (issue) {p_hi, p_lo} <= result;
      if (commit) begin
        hi <= p_hi;
        lo <= p_lo;
      end else begin
        if (wr_hi) hi <= rs_val;
        if (wr_lo) lo <= rs_val;
      end
    end
  end

  assign busy     = (state == BUSY);
  assign md_stall = md_use_D && (busy || long_req);

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - self-checking bench for md_sched (exercises MD_MADD_EN when defined)
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use_D;
  logic        busy, md_stall, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_D (md_use_D),
    .busy     (busy),
    .md_stall (md_stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op issued at edge number c occupies cycles c..c+N-1 (by edge index) and commits at edge c+N.
  int          cyc    = 0;
  int          m_end  = -1;
  bit          m_init = 1'b0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  function automatic bit m_long(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || op == 4'd7 || op == 4'd8;
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  always @(posedge clk) begin
    longint a, b;
    int     sq, sr;
    bit     was_busy;
    cyc++;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_end = -1; m_init = 1'b1;
    end else begin
      was_busy = (cyc - 1 <= m_end);
      if (was_busy) begin
        if (cyc - 1 == m_end) {m_hi, m_lo} = m_pend;
      end else if (start) begin
        a = longint'($signed(rs_val));
        b = longint'($signed(rt_val));
        m_pend = {m_hi, m_lo};
        case (md_op)
          4'd1: m_pend = a * b;
          4'd2: m_pend = {32'd0, rs_val} * {32'd0, rt_val};
          4'd3: if (rt_val != 0) begin
                  sq = $signed(rs_val) / $signed(rt_val);
                  sr = $signed(rs_val) % $signed(rt_val);
                  m_pend = {sr, sq};
                end
          4'd4: if (rt_val != 0) m_pend = {rs_val % rt_val, rs_val / rt_val};
`ifdef MD_MADD_EN
          4'd7: m_pend = {m_hi, m_lo} + a * b;
          4'd8: m_pend = {m_hi, m_lo} - a * b;
`endif
          4'd5: m_hi = rs_val;
          4'd6: m_lo = rs_val;
          default: ;
        endcase
        if (m_long(md_op)) m_end = cyc + (((md_op == 4'd3) || (md_op == 4'd4)) ? 10 : 5) - 1;
      end
    end
  end

  always @(negedge clk) begin
    bit e_busy;
    if (m_init) begin
      e_busy = (cyc <= m_end);
      check("busy", 64'(busy), 64'(e_busy));
      check("done", 64'(done), 64'(e_busy && cyc == m_end));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("md_stall", 64'(md_stall), 64'(md_use_D && (e_busy || (start && m_long(md_op)))));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    start = 1'b1; md_op = op; rs_val = rs; rt_val = rt;
    tick();
    start = 1'b0; md_op = 4'd0;
  endtask

  // Counts remaining busy cycles and done pulses; the bound turns a hang into a failure.
  task automatic wait_idle(input string name, input int exp_n);
    int n = 0;
    int d = 0;
    while (busy && n < 50) begin
      n++;
      if (done) d++;
      tick();
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
    check({name, "_done_pulses"}, 64'(d), 64'(1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 4'd0; rs_val = 0; rt_val = 0; md_use_D = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);

    // mult with D-stage dependency: stall from the issue cycle through completion
    md_use_D = 1'b1;
    start = 1'b1; md_op = 4'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
    #1 check("stall_issue", 64'(md_stall), 64'h1);
    tick();
    start = 1'b0; md_op = 4'd0;
    wait_idle("mult", 5);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFE);
    check("stall_after", 64'(md_stall), 64'h0);
    md_use_D = 1'b0;

    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu", 5);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div", 10);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    issue(4'd4, 32'd7, 32'd0);
    wait_idle("divu0", 10);
    check("divu0_hi", 64'(hi), 64'hFFFF_FFFF);
    check("divu0_lo", 64'(lo), 64'hFFFF_FFFD);

    issue(4'd6, 32'h1234, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_busy", 64'(busy), 64'h0);
    issue(4'd5, 32'hABCD, 32'd0);
    check("mthi_hi", 64'(hi), 64'hABCD);

    // reset in the 3rd busy cycle of a div
    issue(4'd3, 32'd100, 32'd7);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    tick(); tick();

    // start while busy is ignored
    issue(4'd1, 32'd3, 32'd5);
    tick(); tick();
    issue(4'd3, 32'd9, 32'd2);
    wait_idle("ignored", 2);
    check("ign_hi", 64'(hi), 64'h0);
    check("ign_lo", 64'(lo), 64'd15);

    issue(4'd0, 32'd77, 32'd1);
    issue(4'd9, 32'd77, 32'd1);
    check("noop_busy", 64'(busy), 64'h0);
    check("noop_lo", 64'(lo), 64'd15);

`ifdef MD_MADD_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd5, 32'd0);
    issue(4'd7, 32'd3, 32'd4);
    wait_idle("madd", 5);
    check("madd_hi", 64'(hi), 64'h0);
    check("madd_lo", 64'(lo), 64'd17);
    issue(4'd8, 32'd1, 32'd20);
    wait_idle("msub", 5);
    check("msub_hi", 64'(hi), 64'hFFFF_FFFF);
    check("msub_lo", 64'(lo), 64'hFFFF_FFFD);
`else
    md_use_D = 1'b1;
    start = 1'b1; md_op = 4'd7; rs_val = 32'd3; rt_val = 32'd4;
    #1 check("op7_stall", 64'(md_stall), 64'h0);
    tick();
    start = 1'b0; md_op = 4'd0; md_use_D = 1'b0;
    check("op7_busy", 64'(busy), 64'h0);
    check("op7_hi", 64'(hi), 64'h0);
    check("op7_lo", 64'(lo), 64'd15);
`endif

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
